// File: rtl/mcpu_pkg.sv
// Shared definitions for the multicycle CPU control unit:
// opcodes, FSM states, ALU operations and datapath mux encodings.
package mcpu_pkg;

    localparam logic [5:0] OP_NOP  = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000001;
    localparam logic [5:0] OP_MOV  = 6'b010000;
    localparam logic [5:0] OP_NOT  = 6'b010001;
    localparam logic [5:0] OP_ADD  = 6'b010010;
    localparam logic [5:0] OP_SUB  = 6'b010011;
    localparam logic [5:0] OP_OR   = 6'b010100;
    localparam logic [5:0] OP_AND  = 6'b010101;
    localparam logic [5:0] OP_XOR  = 6'b010110;
    localparam logic [5:0] OP_SLT  = 6'b010111;
    localparam logic [5:0] OP_BEQ  = 6'b100000;
    localparam logic [5:0] OP_BNE  = 6'b100001;
    localparam logic [5:0] OP_BLT  = 6'b100010;
    localparam logic [5:0] OP_BLE  = 6'b100011;
    localparam logic [5:0] OP_ADDI = 6'b110010;
    localparam logic [5:0] OP_SUBI = 6'b110011;
    localparam logic [5:0] OP_ORI  = 6'b110100;
    localparam logic [5:0] OP_ANDI = 6'b110101;
    localparam logic [5:0] OP_XORI = 6'b110110;
    localparam logic [5:0] OP_SLTI = 6'b110111;
    localparam logic [5:0] OP_LI   = 6'b111001;
    localparam logic [5:0] OP_LUI  = 6'b111010;
    localparam logic [5:0] OP_LWI  = 6'b111011;
    localparam logic [5:0] OP_SWI  = 6'b111100;
    localparam logic [5:0] OP_LW   = 6'b111101;
    localparam logic [5:0] OP_SW   = 6'b111110;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        ALU_PASS_A = 4'd0,
        ALU_PASS_B = 4'd1,
        ALU_NOT    = 4'd2,
        ALU_ADD    = 4'd3,
        ALU_SUB    = 4'd4,
        ALU_OR     = 4'd5,
        ALU_AND    = 4'd6,
        ALU_XOR    = 4'd7,
        ALU_SLT    = 4'd8,
        ALU_LUI    = 4'd9
    } alu_op_t;

    localparam logic       PC_SRC_ALU = 1'b0;
    localparam logic       PC_SRC_TGT = 1'b1;
    localparam logic       RA_RT      = 1'b0;
    localparam logic       RA_RD      = 1'b1;
    localparam logic [1:0] RB_RT      = 2'd0;
    localparam logic [1:0] RB_RS      = 2'd1;
    localparam logic [1:0] RB_RD      = 2'd2;
    localparam logic [1:0] SRCA_A     = 2'd0;
    localparam logic [1:0] SRCA_PC    = 2'd1;
    localparam logic [1:0] SRCA_ZERO  = 2'd2;
    localparam logic [1:0] SRCB_B     = 2'd0;
    localparam logic [1:0] SRCB_ONE   = 2'd1;
    localparam logic [1:0] SRCB_IMM16 = 2'd2;
    localparam logic [1:0] SRCB_IMM26 = 2'd3;

    typedef struct packed {
        logic    is_r;
        logic    is_i;
        logic    is_li;
        logic    is_lui;
        logic    is_load;
        logic    is_store;
        logic    is_regbase;
        logic    is_branch;
        logic    is_jump;
        logic    is_nop;
        logic    illegal;
        logic    zext;
        alu_op_t alu_op;
    } dec_t;

endpackage

// File: rtl/mcpu_decode.sv
// Opcode classifier: turns the 6-bit opcode into class flags
// and the ALU operation used in EXEC for ALU-class instructions.
module mcpu_decode
    import mcpu_pkg::*;
(
    input  logic [5:0] opcode_i,
    output dec_t       dec_o
);

    always_comb begin
        dec_o = '0;
        dec_o.alu_op = ALU_PASS_A;
        case (opcode_i)
            OP_NOP:  dec_o.is_nop = 1'b1;
            OP_J:    dec_o.is_jump = 1'b1;
            OP_MOV:  dec_o.is_r = 1'b1;
            OP_NOT:  begin dec_o.is_r = 1'b1; dec_o.alu_op = ALU_NOT; end
            OP_ADD:  begin dec_o.is_r = 1'b1; dec_o.alu_op = ALU_ADD; end
            OP_SUB:  begin dec_o.is_r = 1'b1; dec_o.alu_op = ALU_SUB; end
            OP_OR:   begin dec_o.is_r = 1'b1; dec_o.alu_op = ALU_OR;  end
            OP_AND:  begin dec_o.is_r = 1'b1; dec_o.alu_op = ALU_AND; end
            OP_XOR:  begin dec_o.is_r = 1'b1; dec_o.alu_op = ALU_XOR; end
            OP_SLT:  begin dec_o.is_r = 1'b1; dec_o.alu_op = ALU_SLT; end
            OP_BEQ, OP_BNE, OP_BLT, OP_BLE: dec_o.is_branch = 1'b1;
            OP_ADDI: begin dec_o.is_i = 1'b1; dec_o.alu_op = ALU_ADD; end
            OP_SUBI: begin dec_o.is_i = 1'b1; dec_o.alu_op = ALU_SUB; end
            OP_ORI: begin
                dec_o.is_i = 1'b1; dec_o.zext = 1'b1; dec_o.alu_op = ALU_OR;
            end
            OP_ANDI: begin
                dec_o.is_i = 1'b1; dec_o.zext = 1'b1; dec_o.alu_op = ALU_AND;
            end
            OP_XORI: begin
                dec_o.is_i = 1'b1; dec_o.zext = 1'b1; dec_o.alu_op = ALU_XOR;
            end
            OP_SLTI: begin dec_o.is_i = 1'b1; dec_o.alu_op = ALU_SLT; end
            OP_LI: begin
                dec_o.is_li = 1'b1; dec_o.zext = 1'b1; dec_o.alu_op = ALU_PASS_B;
            end
            OP_LUI:  begin dec_o.is_lui = 1'b1; dec_o.alu_op = ALU_LUI; end
            OP_LWI:  begin dec_o.is_load = 1'b1;  dec_o.zext = 1'b1; end
            OP_SWI:  begin dec_o.is_store = 1'b1; dec_o.zext = 1'b1; end
            OP_LW:   begin dec_o.is_load = 1'b1;  dec_o.is_regbase = 1'b1; end
            OP_SW:   begin dec_o.is_store = 1'b1; dec_o.is_regbase = 1'b1; end
            default: dec_o.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mcpu_control.sv
// Multicycle control FSM: sequences fetch/decode/exec/mem/wb,
// handles the data-memory wait and counts retired instructions.
module mcpu_control
    import mcpu_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             alu_zero,
    input  logic             alu_lt,
    input  logic             dmem_ready,
    output logic             ir_write,
    output logic             pc_write,
    output logic             ab_write,
    output logic             target_write,
    output logic             aluout_write,
    output logic             mdr_write,
    output logic             pc_src,
    output logic             ra_sel,
    output logic [1:0]       rb_sel,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [3:0]       alu_op,
    output logic             zext_imm,
    output logic             reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             wb_sel,
    output logic             retire,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count,
    output logic [2:0]       state
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    dec_t              dec;
    logic              taken;
    logic              mem_op;
    logic              ra_dec;
    logic [1:0]        rb_dec;

    mcpu_decode u_dec (
        .opcode_i (opcode),
        .dec_o    (dec)
    );

    assign mem_op = dec.is_load | dec.is_store;
    assign ra_dec = dec.is_branch | dec.is_lui;
    assign rb_dec = dec.is_branch ? RB_RS :
                    dec.is_store  ? RB_RD : RB_RT;

    // Branch kind lives in the two low opcode bits (BEQ/BNE/BLT/BLE)
    always_comb begin
        taken = 1'b0;
        case (opcode[1:0])
            2'd0: taken = alu_zero;
            2'd1: taken = ~alu_zero;
            2'd2: taken = alu_lt;
            2'd3: taken = alu_lt | alu_zero;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        ab_write     = 1'b0;
        target_write = 1'b0;
        aluout_write = 1'b0;
        mdr_write    = 1'b0;
        pc_src       = PC_SRC_ALU;
        ra_sel       = RA_RT;
        rb_sel       = RB_RT;
        alu_src_a    = SRCA_A;
        alu_src_b    = SRCB_B;
        alu_op       = ALU_PASS_A;
        zext_imm     = 1'b0;
        reg_write    = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        wb_sel       = 1'b0;
        retire       = 1'b0;
        illegal_op   = 1'b0;
        // Reset masks every strobe so an aborted instruction writes nothing
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    alu_src_a = SRCA_PC;
                    alu_src_b = SRCB_ONE;
                    alu_op    = ALU_ADD;
                    state_d   = S_DECODE;
                end
                S_DECODE: begin
                    ab_write     = 1'b1;
                    target_write = 1'b1;
                    ra_sel       = ra_dec;
                    rb_sel       = rb_dec;
                    alu_src_a    = SRCA_PC;
                    alu_src_b    = dec.is_jump ? SRCB_IMM26 : SRCB_IMM16;
                    alu_op       = ALU_ADD;
                    if (dec.is_nop || dec.illegal) begin
                        retire     = 1'b1;
                        illegal_op = dec.illegal;
                        state_d    = S_FETCH;
                    end else begin
                        state_d    = S_EXEC;
                    end
                end
                S_EXEC: begin
                    ra_sel = ra_dec;
                    rb_sel = rb_dec;
                    if (dec.is_branch) begin
                        alu_op   = ALU_SUB;
                        pc_write = taken;
                        pc_src   = PC_SRC_TGT;
                        retire   = 1'b1;
                        state_d  = S_FETCH;
                    end else if (dec.is_jump) begin
                        pc_write = 1'b1;
                        pc_src   = PC_SRC_TGT;
                        retire   = 1'b1;
                        state_d  = S_FETCH;
                    end else if (mem_op) begin
                        aluout_write = 1'b1;
                        alu_op       = ALU_ADD;
                        alu_src_a    = dec.is_regbase ? SRCA_A : SRCA_ZERO;
                        alu_src_b    = SRCB_IMM16;
                        zext_imm     = dec.zext;
                        state_d      = S_MEM;
                    end else begin
                        aluout_write = 1'b1;
                        alu_op       = dec.alu_op;
                        alu_src_b    = dec.is_r ? SRCB_B : SRCB_IMM16;
                        zext_imm     = dec.zext;
                        state_d      = S_WB;
                    end
                end
                S_MEM: begin
                    rb_sel    = rb_dec;
                    mem_read  = dec.is_load;
                    mem_write = dec.is_store;
                    if (dmem_ready) begin
                        if (dec.is_load) begin
                            mdr_write = 1'b1;
                            state_d   = S_WB;
                        end else begin
                            retire    = 1'b1;
                            state_d   = S_FETCH;
                        end
                    end
                end
                S_WB: begin
                    reg_write = 1'b1;
                    wb_sel    = dec.is_load;
                    retire    = 1'b1;
                    state_d   = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    assign cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign instr_count = cnt_q;
    assign state       = state_q;

endmodule

// File: tb/tb_mcpu_control.sv
// Directed bench for mcpu_control: reset abort, ALU, branch,
// waited load, illegal opcode and counter wrap at CNT_W = 4.
module tb_mcpu_control;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       alu_zero, alu_lt, dmem_ready;
    logic       ir_write, pc_write, ab_write, target_write;
    logic       aluout_write, mdr_write, pc_src, ra_sel;
    logic [1:0] rb_sel, alu_src_a, alu_src_b;
    logic [3:0] alu_op;
    logic       zext_imm, reg_write, mem_read, mem_write, wb_sel;
    logic       retire, illegal_op;
    logic [3:0] instr_count;
    logic [2:0] state;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mcpu_control #(.CNT_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .alu_zero     (alu_zero),
        .alu_lt       (alu_lt),
        .dmem_ready   (dmem_ready),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .ab_write     (ab_write),
        .target_write (target_write),
        .aluout_write (aluout_write),
        .mdr_write    (mdr_write),
        .pc_src       (pc_src),
        .ra_sel       (ra_sel),
        .rb_sel       (rb_sel),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_op       (alu_op),
        .zext_imm     (zext_imm),
        .reg_write    (reg_write),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .wb_sel       (wb_sel),
        .retire       (retire),
        .illegal_op   (illegal_op),
        .instr_count  (instr_count),
        .state        (state)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; opcode = 6'b000000;
        alu_zero = 1'b0; alu_lt = 1'b0; dmem_ready = 1'b0;
        tick; tick;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_cnt", 32'(instr_count), 32'd0);
        chk("rst_irw", 32'(ir_write), 32'd0);
        chk("rst_pcw", 32'(pc_write), 32'd0);
        chk("rst_aluop", 32'(alu_op), 32'd0);
        rst = 1'b0; #1;
        chk("f_irw", 32'(ir_write), 32'd1);

        // LW stalled in MEM, then reset held 3 cycles
        opcode = 6'b111101;
        tick; tick; tick;
        chk("lw_mem_st", 32'(state), 32'd3);
        chk("lw_mem_rd", 32'(mem_read), 32'd1);
        tick;
        rst = 1'b1; #1;
        chk("ab_memrd", 32'(mem_read), 32'd0);
        chk("ab_memwr", 32'(mem_write), 32'd0);
        chk("ab_regwr", 32'(reg_write), 32'd0);
        chk("ab_mdrw", 32'(mdr_write), 32'd0);
        tick;
        chk("ab_state", 32'(state), 32'd0);
        tick; tick;
        chk("ab_cnt", 32'(instr_count), 32'd0);
        chk("ab_irw", 32'(ir_write), 32'd0);
        chk("ab_ret", 32'(retire), 32'd0);
        rst = 1'b0; #1;

        // ADD: F-D-E-WB
        opcode = 6'b010010; dmem_ready = 1'b1;
        chk("add_f", 32'(state), 32'd0);
        tick;
        chk("add_d", 32'(state), 32'd1);
        chk("add_abw", 32'(ab_write), 32'd1);
        chk("add_tgw", 32'(target_write), 32'd1);
        chk("add_d_rw", 32'(reg_write), 32'd0);
        tick;
        chk("add_e", 32'(state), 32'd2);
        chk("add_aluop", 32'(alu_op), 32'd3);
        chk("add_aow", 32'(aluout_write), 32'd1);
        chk("add_e_rw", 32'(reg_write), 32'd0);
        chk("add_e_ret", 32'(retire), 32'd0);
        tick;
        chk("add_wb", 32'(state), 32'd4);
        chk("add_wb_rw", 32'(reg_write), 32'd1);
        chk("add_wb_ret", 32'(retire), 32'd1);
        chk("add_wbsel", 32'(wb_sel), 32'd0);
        tick;
        chk("add_done", 32'(state), 32'd0);
        chk("add_cnt", 32'(instr_count), 32'd1);

        // BNE not-equal (taken) then equal (not taken)
        opcode = 6'b100001; alu_zero = 1'b0;
        tick; tick;
        chk("bne_t_pcw", 32'(pc_write), 32'd1);
        chk("bne_t_src", 32'(pc_src), 32'd1);
        chk("bne_t_ra", 32'(ra_sel), 32'd1);
        chk("bne_t_rb", 32'(rb_sel), 32'd1);
        chk("bne_t_op", 32'(alu_op), 32'd4);
        chk("bne_t_ret", 32'(retire), 32'd1);
        tick;
        chk("bne_t_st", 32'(state), 32'd0);
        chk("bne_t_cnt", 32'(instr_count), 32'd2);
        alu_zero = 1'b1;
        tick; tick;
        chk("bne_n_pcw", 32'(pc_write), 32'd0);
        chk("bne_n_ret", 32'(retire), 32'd1);
        tick;
        chk("bne_n_st", 32'(state), 32'd0);
        chk("bne_n_cnt", 32'(instr_count), 32'd3);
        alu_zero = 1'b0;

        // LWI with two not-ready cycles
        opcode = 6'b111011; dmem_ready = 1'b0;
        tick; tick;
        chk("lwi_srca", 32'(alu_src_a), 32'd2);
        chk("lwi_srcb", 32'(alu_src_b), 32'd2);
        chk("lwi_zext", 32'(zext_imm), 32'd1);
        tick;
        chk("lwi_m1_rd", 32'(mem_read), 32'd1);
        chk("lwi_m1_mdr", 32'(mdr_write), 32'd0);
        tick;
        chk("lwi_m2_st", 32'(state), 32'd3);
        chk("lwi_m2_rd", 32'(mem_read), 32'd1);
        chk("lwi_m2_mdr", 32'(mdr_write), 32'd0);
        tick;
        dmem_ready = 1'b1; #1;
        chk("lwi_m3_st", 32'(state), 32'd3);
        chk("lwi_m3_rd", 32'(mem_read), 32'd1);
        chk("lwi_m3_mdr", 32'(mdr_write), 32'd1);
        tick;
        chk("lwi_wb_st", 32'(state), 32'd4);
        chk("lwi_wbsel", 32'(wb_sel), 32'd1);
        chk("lwi_wb_rw", 32'(reg_write), 32'd1);
        chk("lwi_wb_ret", 32'(retire), 32'd1);
        tick;
        chk("lwi_done", 32'(state), 32'd0);
        chk("lwi_cnt", 32'(instr_count), 32'd4);

        // Illegal opcode
        opcode = 6'b101010;
        tick;
        chk("ill_st", 32'(state), 32'd1);
        chk("ill_pulse", 32'(illegal_op), 32'd1);
        chk("ill_ret", 32'(retire), 32'd1);
        tick;
        chk("ill_done", 32'(state), 32'd0);
        chk("ill_cnt", 32'(instr_count), 32'd5);
        chk("ill_clr", 32'(illegal_op), 32'd0);

        // 16 NOPs from zero wrap the 4-bit counter
        rst = 1'b1;
        tick;
        rst = 1'b0; opcode = 6'b000000; #1;
        chk("nop_cnt0", 32'(instr_count), 32'd0);
        for (int i = 0; i < 15; i++) begin
            tick; tick;
        end
        chk("nop_cnt15", 32'(instr_count), 32'd15);
        tick;
        chk("nop_d_ret", 32'(retire), 32'd1);
        tick;
        chk("nop_wrap", 32'(instr_count), 32'd0);
        chk("nop_st", 32'(state), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
